repeater_hub_nport: RTL and testbench
=====================================

// Module: repeater_hub_nport
// PURPOSE
//  N-port shared-medium repeater hub at GMII byte level; parametrised successor of the single-port repeater hub.
//  Sits between per-port RGMII DDR-to-SDR converters (outside this block) and the switch fabric.
//  One frame at a time: first port to start a frame wins and is repeated to every other port, never echoed back to its source.
//  Adds collision detection with error propagation and inter-frame-gap enforcement.
// PARAMETERS
//  N_PORTS     4   number of ports, 2..16
//  DATA_W      8   bits per port per cycle
//  IFG_CYCLES  12  idle cycles enforced after a frame; 0 = no gap
//  CNT_W       16  statistics counter width (used only with the macro)
// PORTS
//  clk           in   1               single clock for all ports
//  rst_n         in   1               asynchronous, active-low reset
//  rx_data       in   N_PORTS*DATA_W  port p occupies bits [p*DATA_W +: DATA_W]
//  rx_dv         in   N_PORTS         per-port receive data valid
//  rx_er         in   N_PORTS         per-port receive error
//  tx_data       out  N_PORTS*DATA_W  repeated data, same packing as rx_data
//  tx_en         out  N_PORTS         per-port transmit enable
//  tx_er         out  N_PORTS         per-port transmit error
//  busy          out  1               state != IDLE
//  active_port   out  PW              winning port index, PW = max(1,$clog2(N_PORTS))
//  collision     out  1               one-cycle pulse on the first collision of a frame
// BEHAVIOUR
//  - Reset (async): tx_data, tx_en, tx_er, busy, active_port and collision all go to 0 immediately; state goes to IDLE.
//    rx_dv_q resets to all ones, so a port already mid-frame at reset release stays ineligible until its rx_dv falls.
//  - Eligibility: a port starts a frame only on a rising edge, i.e. rx_dv[p]=1 && rx_dv_q[p]=0.
//  - IDLE: the lowest-index eligible port wins. Capture winner into active_port and go to FWD.
//    If more than one port is eligible in the same cycle, that counts as a collision.
//  - FWD: every output reg is registered; latency is exactly 1 cycle from rx to tx.
//    For each p != winner: tx_data[p] = rx_data[winner], tx_en[p] = rx_dv[winner], tx_er[p] = rx_er[winner] | jam.
//    tx_en, tx_data and tx_er of the winner port are held at 0.
//  - Collision: in FWD, or on the IDLE tie, any non-winner port with rx_dv=1 sets the jam flag.
//    jam forces tx_er=1 on all forwarding ports for the remaining bytes of the frame.
//    collision pulses once, on the cycle after the first detection. Data from losing ports is discarded.
//  - End of frame: rx_dv[winner]=0 in FWD -> tx_en goes to 0 on the next cycle; jam clears.
//    If IFG_CYCLES>0, go to GAP with the counter loaded to IFG_CYCLES-1; otherwise go to IDLE.
//  - GAP: all tx outputs are 0; the counter decrements each cycle; at 0, go to IDLE.
//    A port that rises during GAP keeps rx_dv_q=1, so its frame is dropped entirely, never truncated.
//  - A winner that falls and rises again within GAP is likewise dropped.
//  - busy=1 in FWD and GAP. active_port holds its last value in IDLE.
// CONFIGURATION
//  - REPEATER_HUB_STATS_EN defined: adds outputs frame_cnt[CNT_W] and coll_cnt[CNT_W].
//    frame_cnt increments on every IDLE->FWD transition. coll_cnt increments on every collision pulse.
//    Both counters saturate at all-ones and reset to 0.
//  - Macro undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package repeater_hub_pkg: state typedef {IDLE, FWD, GAP}; function pw(n) returning the active_port width.
//  - Sub-module repeater_hub_arb: combinational fixed-priority picker over N_PORTS eligible bits.
//    Outputs: a valid flag, the winning index, and a multiple-request flag used for the tie collision.
//  - Top: FSM, gap counter, rx_dv_q, jam flag, output registers and optional counters.
// TESTING
//  - Reset release with rx_dv[2] already 1: no forwarding until port 2 drops and re-rises; all outputs 0 until then.
//  - Port 1 sends a 64-byte frame: ports 0, 2 and 3 see identical bytes 1 cycle later;
//    tx_en[1]=0 throughout; active_port=1; busy stays high through 12 GAP cycles.
//  - Ports 0 and 3 rise in the same cycle: port 0 wins; collision pulses once; tx_er=1 on ports 1..3 for the whole frame.
//  - Port 2 starts during port 0's frame at byte 10: collision pulse; tx_er=1 from byte 10 onward; port 2 bytes never appear.
//  - Port 3 rises in GAP cycle 5 and its frame lasts 40 bytes: nothing is forwarded; the next frame on port 3 is forwarded normally.
//  - Assert rst_n=0 mid-frame: all tx outputs are 0 in the same cycle; with stats enabled, frame_cnt returns to 0.

Source files
------------

// File: rtl/repeater_hub_pkg.sv
// Shared state type and width helper for the N-port GMII repeater hub.
package repeater_hub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        GAP  = 2'd2
    } hub_state_e;

    // Width of the active_port index: max(1, clog2(n)).
    function automatic int unsigned pw(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 2) begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/repeater_hub_arb.sv
// Combinational fixed-priority picker: lowest-index request wins, multi flags a tie.
module repeater_hub_arb
    import repeater_hub_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned PW      = pw(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    output logic               valid,
    output logic [PW-1:0]      idx,
    output logic               multi
);

    always_comb begin
        idx = '0;
        for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = PW'(i);
            end
        end
    end

    assign valid = |req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(req & (req - N_PORTS'(1)));

endmodule

// File: rtl/repeater_hub_nport.sv
// N-port shared-medium GMII repeater hub with collision jam and inter-frame gap.
// Optional statistics counters are enabled by defining REPEATER_HUB_STATS_EN.
module repeater_hub_nport
    import repeater_hub_pkg::*;
#(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS*DATA_W-1:0] rx_data,
    input  logic [N_PORTS-1:0]        rx_dv,
    input  logic [N_PORTS-1:0]        rx_er,
    output logic [N_PORTS*DATA_W-1:0] tx_data,
    output logic [N_PORTS-1:0]        tx_en,
    output logic [N_PORTS-1:0]        tx_er,
    output logic                      busy,
    output logic [pw(N_PORTS)-1:0]    active_port,
    output logic                      collision
`ifdef REPEATER_HUB_STATS_EN
    ,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic [CNT_W-1:0]          coll_cnt
`endif
);

    localparam int unsigned PW = pw(N_PORTS);
    localparam int unsigned GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : '0;

    hub_state_e state_q, state_d;

    logic [N_PORTS-1:0]        rx_dv_q;
    logic [N_PORTS-1:0]        eligible;
    logic [N_PORTS-1:0]        win_oh;
    logic [PW-1:0]             active_port_q, active_port_d;
    logic [PW-1:0]             arb_idx;
    logic [PW-1:0]             cur_idx;
    logic                      arb_valid;
    logic                      arb_multi;
    logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
    logic                      jam_q, jam_d;
    logic                      start;
    logic                      fwd_now;
    logic                      coll_now;
    logic                      win_dv;
    logic                      win_er;
    logic [DATA_W-1:0]         win_data;
    logic [N_PORTS*DATA_W-1:0] tx_data_q, tx_data_d;
    logic [N_PORTS-1:0]        tx_en_q, tx_en_d;
    logic [N_PORTS-1:0]        tx_er_q, tx_er_d;
    logic                      collision_q, collision_d;

    // A port may only claim the medium on the rising edge of its rx_dv.
    assign eligible = rx_dv & ~rx_dv_q;

    repeater_hub_arb #(
        .N_PORTS (N_PORTS),
        .PW      (PW)
    ) u_arb (
        .req   (eligible),
        .valid (arb_valid),
        .idx   (arb_idx),
        .multi (arb_multi)
    );

    // In IDLE the fresh arbitration result is the winner; otherwise the captured one.
    always_comb begin
        cur_idx  = (state_q == IDLE) ? arb_idx : active_port_q;
        win_oh   = '0;
        win_data = '0;
        win_dv   = 1'b0;
        win_er   = 1'b0;
        for (int p = 0; p < int'(N_PORTS); p++) begin
            if (cur_idx == PW'(p)) begin
                win_oh[p] = 1'b1;
                win_data  = rx_data[p*DATA_W +: DATA_W];
                win_dv    = rx_dv[p];
                win_er    = rx_er[p];
            end
        end
    end

    assign start    = (state_q == IDLE) && arb_valid;
    assign fwd_now  = start || ((state_q == FWD) && win_dv);
    assign coll_now = (start && arb_multi) ||
                      ((state_q == FWD) && win_dv && (|(rx_dv & ~win_oh)));

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = FWD;
                end
            end
            FWD: begin
                if (!win_dv) begin
                    state_d = (IFG_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath next state: repeat the winner to every other port, one cycle later.
    always_comb begin
        tx_data_d = '0;
        tx_en_d   = '0;
        tx_er_d   = '0;
        if (fwd_now) begin
            for (int p = 0; p < int'(N_PORTS); p++) begin
                if (!win_oh[p]) begin
                    tx_data_d[p*DATA_W +: DATA_W] = win_data;
                    tx_en_d[p]                    = 1'b1;
                    tx_er_d[p]                    = win_er | jam_q | coll_now;
                end
            end
        end
        jam_d         = fwd_now & (jam_q | coll_now);
        collision_d   = coll_now & ~jam_q;
        active_port_d = start ? arb_idx : active_port_q;
    end

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if ((state_q == FWD) && !win_dv) begin
            gap_cnt_d = GAP_LOAD;
        end else if ((state_q == GAP) && (gap_cnt_q != '0)) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dv_q       <= '1;
            active_port_q <= '0;
            gap_cnt_q     <= '0;
            jam_q         <= 1'b0;
            tx_data_q     <= '0;
            tx_en_q       <= '0;
            tx_er_q       <= '0;
            collision_q   <= 1'b0;
        end else begin
            rx_dv_q       <= rx_dv;
            active_port_q <= active_port_d;
            gap_cnt_q     <= gap_cnt_d;
            jam_q         <= jam_d;
            tx_data_q     <= tx_data_d;
            tx_en_q       <= tx_en_d;
            tx_er_q       <= tx_er_d;
            collision_q   <= collision_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;
    assign tx_er       = tx_er_q;
    assign active_port = active_port_q;
    assign collision   = collision_q;

`ifdef REPEATER_HUB_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] coll_cnt_q, coll_cnt_d;

    // Saturating counters; coll_cnt steps on the same edge the collision pulse rises.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        coll_cnt_d  = coll_cnt_q;
        if (start && !(&frame_cnt_q)) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (collision_d && !(&coll_cnt_q)) begin
            coll_cnt_d = coll_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            coll_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign coll_cnt  = coll_cnt_q;
`endif

endmodule

// File: tb/tb_repeater_hub_nport.sv
// Self-checking bench for repeater_hub_nport: frame-level expectation tables plus literal pins.
module tb_repeater_hub_nport;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int IFG  = 12;
    localparam int NCYC = 320;

    logic            clk;
    logic            rst_n;
    logic [N*W-1:0]  rx_data;
    logic [N-1:0]    rx_dv;
    logic [N-1:0]    rx_er;
    logic [N*W-1:0]  tx_data;
    logic [N-1:0]    tx_en;
    logic [N-1:0]    tx_er;
    logic            busy;
    logic [1:0]      active_port;
    logic            collision;
`ifdef REPEATER_HUB_STATS_EN
    logic [15:0]     frame_cnt;
    logic [15:0]     coll_cnt;
`endif

    repeater_hub_nport #(
        .N_PORTS    (N),
        .DATA_W     (W),
        .IFG_CYCLES (IFG),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_dv       (rx_dv),
        .rx_er       (rx_er),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_er       (tx_er),
        .busy        (busy),
        .active_port (active_port),
        .collision   (collision)
`ifdef REPEATER_HUB_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .coll_cnt    (coll_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus schedule and expected outputs, indexed by cycle after reset release.
    logic [N-1:0]   stim_dv   [NCYC];
    logic [N-1:0]   stim_er   [NCYC];
    logic [N*W-1:0] stim_data [NCYC];
    logic [N-1:0]   want_en   [NCYC];
    logic [N-1:0]   want_er   [NCYC];
    logic [N*W-1:0] want_data [NCYC];
    logic           want_busy [NCYC];
    logic           want_coll [NCYC];
    logic [1:0]     want_ap   [NCYC];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit run     = 1'b0;

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, want);
        end
    endtask

    // Byte k of a frame from port p: port in the top two bits, byte index below.
    function automatic logic [7:0] bval(input int p, input int k);
        return 8'((p << 6) | (k & 63));
    endfunction

    task automatic sched(input int p, input int s, input int len);
        for (int k = 0; k < len; k++) begin
            if (s + k < NCYC) begin
                stim_dv[s+k][p]         = 1'b1;
                stim_data[s+k][p*W +: W] = bval(p, k);
            end
        end
    endtask

    // A forwarded frame: bytes appear one cycle late on every other port, jammed
    // from byte j onward (j >= len means no collision), then IFG gap cycles of busy.
    task automatic expect_fwd(input int w, input int s, input int len, input int j);
        for (int k = 0; k < len; k++) begin
            int c;
            c = s + 1 + k;
            if (c < NCYC) begin
                for (int p = 0; p < N; p++) begin
                    if (p != w) begin
                        want_en[c][p]          = 1'b1;
                        want_data[c][p*W +: W] = bval(w, k);
                        want_er[c][p]          = (k >= j);
                    end
                end
            end
        end
        for (int c = s + 1; c <= s + len + IFG && c < NCYC; c++) want_busy[c] = 1'b1;
        for (int c = s + 1; c < NCYC; c++) want_ap[c] = 2'(w);
        if (j < len && s + j + 1 < NCYC) want_coll[s+j+1] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("tx_en", cyc, 32'(tx_en), 32'(want_en[cyc]));
            chk("tx_er", cyc, 32'(tx_er), 32'(want_er[cyc]));
            chk("tx_data", cyc, 32'(tx_data), 32'(want_data[cyc]));
            chk("busy", cyc, 32'(busy), 32'(want_busy[cyc]));
            chk("collision", cyc, 32'(collision), 32'(want_coll[cyc]));
            chk("active_port", cyc, 32'(active_port), 32'(want_ap[cyc]));
            case (cyc)
                13:  begin
                    chk("lit_p2_byte0", cyc, 32'(tx_data), 32'h80008080);
                    chk("lit_p2_en", cyc, 32'(tx_en), 32'hb);
                end
                41:  begin
                    chk("lit_p1_byte0", cyc, 32'(tx_data), 32'h40400040);
                    chk("lit_p1_en", cyc, 32'(tx_en), 32'hd);
                end
                61:  chk("lit_rx_er", cyc, 32'(tx_er), 32'hd);
                116: chk("lit_gap_last_busy", cyc, 32'(busy), 32'h1);
                117: chk("lit_idle_after_gap", cyc, 32'(busy), 32'h0);
                131: begin
                    chk("lit_tie_pulse", cyc, 32'(collision), 32'h1);
                    chk("lit_tie_jam", cyc, 32'(tx_er), 32'he);
                    chk("lit_tie_winner", cyc, 32'(active_port), 32'h0);
                end
                132: chk("lit_tie_pulse_once", cyc, 32'(collision), 32'h0);
                180: chk("lit_prejam", cyc, 32'(tx_er), 32'h0);
                181: begin
                    chk("lit_midjam_pulse", cyc, 32'(collision), 32'h1);
                    chk("lit_midjam_er", cyc, 32'(tx_er), 32'he);
                    chk("lit_midjam_data", cyc, 32'(tx_data), 32'h0a0a0a00);
                end
                220: chk("lit_gap_drop", cyc, 32'(tx_en), 32'h0);
                251: begin
                    chk("lit_p3_byte0", cyc, 32'(tx_data), 32'h00c0c0c0);
                    chk("lit_p3_winner", cyc, 32'(active_port), 32'h3);
                end
                default: ;
            endcase
        end
    end

    initial begin
        rst_n   = 1'b1;
        rx_dv   = 4'b0100;
        rx_data = '0;
        rx_er   = '0;
        for (int c = 0; c < NCYC; c++) begin
            stim_dv[c]   = '0;
            stim_er[c]   = '0;
            stim_data[c] = '0;
            want_en[c]   = '0;
            want_er[c]   = '0;
            want_data[c] = '0;
            want_busy[c] = 1'b0;
            want_coll[c] = 1'b0;
            want_ap[c]   = '0;
        end

        // Port 2 already high at release; drops at 10, real frame at 12.
        sched(2, 0, 10);
        sched(2, 12, 8);
        expect_fwd(2, 12, 8, 8);
        // 64-byte frame from port 1 with one rx_er byte.
        sched(1, 40, 64);
        stim_er[60][1] = 1'b1;
        expect_fwd(1, 40, 64, 64);
        want_er[61] = want_er[61] | 4'b1101;
        // Ports 0 and 3 tie.
        sched(0, 130, 20);
        sched(3, 130, 20);
        expect_fwd(0, 130, 20, 0);
        // Port 2 intrudes at byte 10 of port 0's frame.
        sched(0, 170, 30);
        sched(2, 180, 5);
        expect_fwd(0, 170, 30, 10);
        // Port 3 rises in gap cycle 5 (dropped), then a clean frame.
        sched(3, 205, 40);
        sched(3, 250, 10);
        expect_fwd(3, 250, 10, 10);
        // Winner re-rises inside its own gap: dropped.
        sched(1, 280, 6);
        sched(1, 290, 5);
        expect_fwd(1, 280, 6, 6);
        // Frame still running when the bench hits reset.
        sched(1, 305, 100);
        expect_fwd(1, 305, 100, 100);

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_en", -1, 32'(tx_en), 32'h0);
        chk("rst_tx_data", -1, 32'(tx_data), 32'h0);
        chk("rst_tx_er", -1, 32'(tx_er), 32'h0);
        chk("rst_busy", -1, 32'(busy), 32'h0);
        chk("rst_active_port", -1, 32'(active_port), 32'h0);
        chk("rst_collision", -1, 32'(collision), 32'h0);

        run = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            cyc     = c;
            rst_n   = 1'b1;
            rx_dv   = stim_dv[c];
            rx_er   = stim_er[c];
            rx_data = stim_data[c];
            @(posedge clk);
            #1;
        end
        run = 1'b0;

        chk("pre_rst_fwd", NCYC, 32'(tx_en), 32'hd);
`ifdef REPEATER_HUB_STATS_EN
        chk("frame_cnt", NCYC, 32'(frame_cnt), 32'd7);
        chk("coll_cnt", NCYC, 32'(coll_cnt), 32'd2);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx_en", NCYC, 32'(tx_en), 32'h0);
        chk("midrst_tx_data", NCYC, 32'(tx_data), 32'h0);
        chk("midrst_tx_er", NCYC, 32'(tx_er), 32'h0);
        chk("midrst_busy", NCYC, 32'(busy), 32'h0);
`ifdef REPEATER_HUB_STATS_EN
        chk("midrst_frame_cnt", NCYC, 32'(frame_cnt), 32'd0);
`endif
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
